// File: rtl/keyboard_pkg.sv
// Shared types for the PS/2 keyboard event path: scan-code prefixes,
// handshake FSM states and the event word handed to the synth logic.
package keyboard_pkg;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACK      = 2'd1,
      ST_WAIT_CLR = 2'd2
   } kbd_ctl_state_t;

   typedef struct packed {
      logic       is_release;
      logic       extended;
      logic [6:0] code;
   } kbd_event_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// Small valid/ready event FIFO. A push on a full FIFO only lands when the
// head is popped in the same cycle; the head reads as zero while empty.
module kbd_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clock50,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_fire;
   logic             pop_fire;

   assign full      = (count_reg == (AW+1)'(DEPTH));
   assign pop_valid = (count_reg != '0);
   assign pop_fire  = pop_valid && pop_ready;
   assign push_fire = push && (!full || pop_fire);
   assign pop_data  = pop_valid ? mem[rd_ptr_reg] : '0;

   always_ff @(posedge clock50) begin
      if (push_fire) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clock50) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_fire) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_fire) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push_fire, pop_fire})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/keyboard_event_controller.sv
// PS/2 scan-code sequencer: handshakes each byte with the receiver, folds
// E0/F0 prefixes, drops typematic repeats and queues press/release events.
module keyboard_event_controller
   import keyboard_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int READ_HOLD      = 4,
   parameter int PREFIX_TIMEOUT = 2_500_000
) (
   input  logic       clock50,
   input  logic       reset,
   input  logic       scan_ready,
   input  logic [7:0] scan_code,
   output logic       read,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [8:0] ev_data,
   output logic       overflow,
   output logic       bad_code
);

   localparam int HW = $clog2(READ_HOLD);
   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

   logic           sync_a_reg;
   logic           rdy_s;
   kbd_ctl_state_t state_reg, state_next;
   logic [HW-1:0]  hold_cnt_reg, hold_cnt_next;
   logic           read_reg, read_next;
   logic           capture;
   logic [7:0]     code_q;

   logic           ext_pend_reg, ext_pend_next;
   logic           brk_pend_reg, brk_pend_next;
   logic [TW-1:0]  timer_reg;
   logic           timeout_hit;

   logic [255:0]   held_reg;
   logic [7:0]     key_idx;
   logic           held_bit;
   logic           decode_en;
   logic           set_held;
   logic           clr_held;
   logic           bad_next;
   logic           bad_code_reg;
   logic           overflow_reg;

   logic           ev_push;
   kbd_event_t     ev_word;
   logic           fifo_full;
   logic           drop;

   always_ff @(posedge clock50) begin
      if (!reset) begin
         sync_a_reg <= 1'b0;
         rdy_s      <= 1'b0;
      end else begin
         sync_a_reg <= scan_ready;
         rdy_s      <= sync_a_reg;
      end
   end

   always_ff @(posedge clock50) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         hold_cnt_reg <= '0;
         read_reg     <= 1'b0;
         code_q       <= '0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         read_reg     <= read_next;
         if (capture) begin
            code_q <= scan_code;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      capture       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (rdy_s) begin
               capture       = 1'b1;
               hold_cnt_next = '0;
               state_next    = ST_ACK;
            end
         end
         ST_ACK: begin
            if (hold_cnt_reg == HW'(READ_HOLD - 1)) begin
               state_next = ST_WAIT_CLR;
            end else begin
               hold_cnt_next = hold_cnt_reg + HW'(1);
            end
         end
         ST_WAIT_CLR: begin
            if (!rdy_s) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      read_next = (state_next == ST_ACK);
   end

   assign read        = read_reg;
   assign decode_en   = (state_reg == ST_ACK) && (hold_cnt_reg == '0);
   assign key_idx     = {ext_pend_reg, code_q[6:0]};
   assign held_bit    = held_reg[key_idx];
   assign timeout_hit = (timer_reg == TW'(PREFIX_TIMEOUT));

   always_comb begin
      ext_pend_next = ext_pend_reg;
      brk_pend_next = brk_pend_reg;
      set_held      = 1'b0;
      clr_held      = 1'b0;
      bad_next      = 1'b0;
      ev_push       = 1'b0;
      ev_word       = '0;
      if (timeout_hit) begin
         ext_pend_next = 1'b0;
         brk_pend_next = 1'b0;
      end
      if (decode_en) begin
         if (code_q == SC_EXT) begin
            ext_pend_next = 1'b1;
         end else if (code_q == SC_BRK) begin
            brk_pend_next = 1'b1;
         end else begin
            ext_pend_next = 1'b0;
            brk_pend_next = 1'b0;
            if (code_q[7]) begin
               bad_next = 1'b1;
            end else if (brk_pend_reg) begin
               // A break for a key we never saw pressed is silently ignored.
               if (held_bit) begin
                  clr_held = 1'b1;
                  ev_push  = 1'b1;
               end
            end else if (!held_bit) begin
               set_held = 1'b1;
               ev_push  = 1'b1;
            end
         end
      end
      ev_word.is_release = brk_pend_reg;
      ev_word.extended   = ext_pend_reg;
      ev_word.code       = code_q[6:0];
   end

   always_ff @(posedge clock50) begin
      if (!reset) begin
         ext_pend_reg <= 1'b0;
         brk_pend_reg <= 1'b0;
         bad_code_reg <= 1'b0;
      end else begin
         ext_pend_reg <= ext_pend_next;
         brk_pend_reg <= brk_pend_next;
         bad_code_reg <= bad_next;
      end
   end

   // Only a prefix stranded in IDLE ages; a fresh byte restarts the count.
   always_ff @(posedge clock50) begin
      if (!reset || capture || timeout_hit || !(ext_pend_reg || brk_pend_reg)) begin
         timer_reg <= '0;
      end else if (state_reg == ST_IDLE) begin
         timer_reg <= timer_reg + TW'(1);
      end
   end

   always_ff @(posedge clock50) begin
      if (!reset) begin
         held_reg <= '0;
      end else if (set_held) begin
         held_reg[key_idx] <= 1'b1;
      end else if (clr_held) begin
         held_reg[key_idx] <= 1'b0;
      end
   end

   assign drop = ev_push && fifo_full && !(ev_valid && ev_ready);

   always_ff @(posedge clock50) begin
      if (!reset) begin
         overflow_reg <= 1'b0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
      end
   end

   assign overflow = overflow_reg;
   assign bad_code = bad_code_reg;

   kbd_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clock50   (clock50),
      .reset     (reset),
      .push      (ev_push),
      .push_data (ev_word),
      .full      (fifo_full),
      .pop_valid (ev_valid),
      .pop_ready (ev_ready),
      .pop_data  (ev_data)
   );

endmodule
